scratch_pad_stream_reader: RTL and testbench
============================================

// Module: scratch_pad_stream_reader
// PURPOSE
//  Read-side client for one scratch_pad port. On a command (base, count) it issues
//  `count` sequential read requests, honouring the port's full signal. It collects
//  the in-order returned words into a local return FIFO and presents them as a
//  valid/stall stream to the consumer. It sits between an accelerator lane and one
//  scratch_pad port; one instance per port.
// PARAMETERS
//  WIDTH        64   data word width; equals scratch_pad WIDTH
//  ADDR_WIDTH   12   scratch_pad address width (4096 words = 512 x 8 ports)
//  COUNT_WIDTH  16   width of the request-count field
//  FIFO_DEPTH   16   return FIFO entries; power of 2; also the max in-flight reads
// PORTS
//  clk         in   1            clock
//  rst         in   1            synchronous, active-high reset
//  start       in   1            command strobe; accepted only in IDLE
//  base_addr   in   ADDR_WIDTH   first word address
//  count       in   COUNT_WIDTH  number of words to read
//  busy        out  1            high from accepted start until done
//  done        out  1            one-cycle pulse: all words issued, returned and consumed
//  sp_rd_en    out  1            read request to the scratch_pad port
//  sp_addr     out  ADDR_WIDTH   request address
//  sp_full     in   1            scratch_pad port full; no request may issue while high
//  sp_q        in   WIDTH        returned read data
//  sp_valid    in   1            sp_q valid this cycle (in request order)
//  sp_stall    out  1            back-pressure to the scratch_pad port = return FIFO full
//  out_data    out  WIDTH        stream data (FIFO head)
//  out_valid   out  1            stream data valid (FIFO not empty)
//  out_stall   in   1            consumer back-pressure
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, sp_rd_en=0, sp_addr=0, sp_stall=0,
//    out_valid=0; FIFO emptied; outstanding=0, remaining=0.
//  - FSM states: IDLE, ISSUE, DRAIN, DONE.
//    IDLE->ISSUE on start with count!=0; latch addr_reg=base_addr, remaining=count.
//    IDLE->DONE on start with count==0.
//    ISSUE->DRAIN on the cycle the last request issues (remaining 1->0).
//    DRAIN->DONE when outstanding==0 and FIFO empty. DONE->IDLE unconditionally;
//    done=1 only in DONE.
//  - busy = (state != IDLE). start is ignored outside IDLE; no queuing.
//  - Issue, combinational: sp_rd_en = ISSUE && remaining!=0 && !sp_full
//    && (outstanding + fifo_count < FIFO_DEPTH). sp_addr = addr_reg.
//    On issue: addr_reg+1, wrapping modulo 2^ADDR_WIDTH (0xFFF -> 0x000);
//    remaining-1; outstanding+1.
//  - Credit rule: outstanding + fifo_count never exceeds FIFO_DEPTH. A return
//    therefore always finds space, and sp_stall must stay 0 in normal operation.
//    The bench asserts this.
//  - Return: sp_valid pushes sp_q and decrements outstanding. Issue and return
//    in the same cycle leave outstanding unchanged. sp_valid with outstanding==0
//    (stale data after reset) is dropped and does not underflow the counter.
//  - Stream: out_valid = !empty; pop when out_valid && !out_stall. out_data is
//    stable while out_valid && out_stall. Push and pop in the same cycle are
//    legal, including when the FIFO is full (pop first) or empty (no bypass;
//    data appears next cycle).
//  - Latency: first out_valid no earlier than scratch_pad read latency + 1 cycle
//    after the first sp_rd_en.
//  - rst mid-operation: aborts the command immediately and all state returns to
//    reset values. In-flight returns arriving afterwards are dropped by the
//    outstanding==0 rule.
//  - Arithmetic: outstanding and fifo_count are log2(FIFO_DEPTH)+1 bits.
//    remaining is COUNT_WIDTH bits. count = 2^COUNT_WIDTH-1 is legal.
// TESTING
//  1. base=0x010, count=4, sp_full=0, out_stall=0, memory[i]=i
//     -> sp_addr 0x010..0x013 on 4 consecutive cycles; out_data 0x10..0x13 in order;
//     single done pulse.
//  2. base=0xFFE, count=4
//     -> sp_addr sequence 0xFFE,0xFFF,0x000,0x001; data returned in the same order.
//  3. count=40, out_stall=1 throughout
//     -> exactly 16 sp_rd_en then issue halts; sp_stall stays 0. Release out_stall
//     -> remaining 24 issue; all 40 words out; done.
//  4. count=8, sp_full toggled high every other cycle
//     -> no sp_rd_en while sp_full=1; 8 requests total; done after the last word
//     is popped.
//  5. count=0 -> done one cycle after start, no sp_rd_en. start asserted while
//     busy -> ignored; the active command completes unchanged.
//  6. rst after 5 of 20 requests issued -> next cycle busy=0, out_valid=0;
//     late sp_valid pulses dropped; a new count=2 command completes correctly.

Source files
------------

// File: rtl/scratch_pad_stream_reader.sv
// Read-side client for one scratch_pad port: issues sequential reads under a credit
// limit and streams the in-order returns through a local FIFO to the consumer.
module scratch_pad_stream_reader #(
  parameter int WIDTH       = 64,
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   sp_rd_en,
  output logic [ADDR_WIDTH-1:0]  sp_addr,
  input  logic                   sp_full,
  input  logic [WIDTH-1:0]       sp_q,
  input  logic                   sp_valid,
  output logic                   sp_stall,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_stall
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          fifo_count;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [WIDTH-1:0]       mem [FIFO_DEPTH];
  logic [CW:0]            credit_used;
  logic                   issue, push, pop, fifo_full, fifo_empty;

  // Every issued read owns a FIFO slot until it is popped, so a return never overflows.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign issue       = (state == ISSUE) && (remaining != '0) && !sp_full &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign pop         = !fifo_empty && !out_stall;
  // Returns with nothing outstanding are stale reads from before a reset.
  assign push        = sp_valid && (outstanding != '0) && (!fifo_full || pop);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sp_rd_en  = issue;
  assign sp_addr   = addr_reg;
  assign sp_stall  = fifo_full && (outstanding != '0);
  assign out_valid = !fifo_empty;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count != '0) ? ISSUE : DONE;
      ISSUE:   if (issue && (remaining == COUNT_WIDTH'(1))) state_nxt = DRAIN;
      DRAIN:   if ((outstanding == '0) && fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_reg    <= '0;
      remaining   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start && (count != '0)) begin
        addr_reg  <= base_addr;
        remaining <= count;
      end else if (issue) begin
        addr_reg  <= addr_reg + ADDR_WIDTH'(1);
        remaining <= remaining - COUNT_WIDTH'(1);
      end
      case ({issue, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sp_q;
  end

endmodule

// File: tb/tb_scratch_pad_stream_reader.sv
// Bench for scratch_pad_stream_reader: a fixed-latency scratch_pad model plus a
// command-level reference (address sequence base+i mod 4096, data mem[addr]).
module tb_scratch_pad_stream_reader;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        busy, done, sp_rd_en, sp_stall, out_valid;
  logic [11:0] sp_addr;
  logic        sp_full = 1'b0;
  logic [63:0] sp_q, out_data;
  logic        sp_valid;
  logic        out_stall = 1'b0;

  logic [63:0] mem [4096];
  logic [L-1:0] vpipe = '0;
  logic [63:0]  q0 = '0, q1 = '0;

  int tests = 0, fails = 0;
  int viol = 0, cyc_g = 0, inflight = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, last_pop = 0, first_ov = -1;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic [11:0] iss_q[$];
  int          iss_cyc[$];
  logic [63:0] out_q[$];

  always #5 clk = ~clk;

  scratch_pad_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .sp_rd_en(sp_rd_en), .sp_addr(sp_addr),
    .sp_full(sp_full), .sp_q(sp_q), .sp_valid(sp_valid), .sp_stall(sp_stall),
    .out_data(out_data), .out_valid(out_valid), .out_stall(out_stall)
  );

  assign sp_valid = vpipe[L-1];
  assign sp_q     = q1;

  // scratch_pad port model: request at edge e returns data sampled at edge e+L
  initial forever begin
    @(posedge clk);
    vpipe <= {vpipe[L-2:0], sp_rd_en};
    q0    <= mem[sp_addr];
    q1    <= q0;
  end

  // protocol monitor and transaction capture
  initial forever begin
    @(posedge clk);
    cyc_g++;
    if (rst) begin
      inflight  = 0;
      prev_hold = 1'b0;
    end else begin
      if (sp_stall) viol++;
      if (sp_rd_en) begin
        if (sp_full || !busy) viol++;
        iss_q.push_back(sp_addr);
        iss_cyc.push_back(cyc_g);
        inflight++;
      end
      if (out_valid && first_ov < 0) first_ov = cyc_g;
      if (out_valid && !out_stall) begin
        out_q.push_back(out_data);
        inflight--;
        last_pop = cyc_g;
      end
      if (inflight > 16 || inflight < 0) viol++;
      if (prev_hold && (!out_valid || out_data !== prev_data)) viol++;
      prev_hold = out_valid && out_stall;
      prev_data = out_data;
      if (done) begin done_cnt++; done_cyc = cyc_g; end
      if (start && !busy) start_cyc = cyc_g;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // fm: 0 never full, 1 toggle, 2 random. sm: 0 never, 1 random, 2 held then released.
  task automatic run_cmd(input string nm, input logic [11:0] b, input int n,
                         input int fm, input int sm, input bit ign);
    int cyc = 0;
    int d0 = done_cnt;
    int v0 = viol;
    int bad_a = 0, bad_d = 0;
    iss_q.delete(); iss_cyc.delete(); out_q.delete();
    first_ov = -1;
    @(negedge clk);
    start = 1'b1; base_addr = b; count = 16'(n);
    sp_full = 1'b0; out_stall = (sm == 2);
    while (done_cnt == d0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = ign && (cyc == 3);
      if (start) begin base_addr = 12'h300; count = 16'd3; end
      case (fm)
        1:       sp_full = ~sp_full;
        2:       sp_full = ($urandom_range(0, 2) == 0);
        default: sp_full = 1'b0;
      endcase
      case (sm)
        1: out_stall = ($urandom_range(0, 3) == 0);
        2: begin
          if (cyc == 60) chk({nm, ".halt16"}, 64'(iss_q.size()), 64'((n < 16) ? n : 16));
          out_stall = (cyc < 60);
        end
        default: out_stall = 1'b0;
      endcase
    end
    start = 1'b0; sp_full = 1'b0; out_stall = 1'b0;
    chk({nm, ".done_seen"}, 64'(done_cnt != d0), 64'd1);
    chk({nm, ".n_issued"}, 64'(iss_q.size()), 64'(n));
    chk({nm, ".n_out"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < iss_q.size(); i++)
      if (iss_q[i] !== 12'((int'(b) + i) % 4096)) bad_a++;
    for (int i = 0; i < n && i < out_q.size(); i++)
      if (out_q[i] !== mem[12'((int'(b) + i) % 4096)]) bad_d++;
    chk({nm, ".addr_seq_errs"}, 64'(bad_a), 64'd0);
    chk({nm, ".data_seq_errs"}, 64'(bad_d), 64'd0);
    chk({nm, ".protocol_viol"}, 64'(viol - v0), 64'd0);
    if (n == 0) chk({nm, ".done_lat"}, 64'(done_cyc - start_cyc), 64'd1);
    else begin
      chk({nm, ".done_after_pop"}, 64'(done_cyc > last_pop), 64'd1);
      chk({nm, ".first_out_lat"}, 64'(first_ov - iss_cyc[0] >= L + 1), 64'd1);
    end
    if (fm == 0 && n > 0 && n <= 16 && iss_cyc.size() == n)
      chk({nm, ".back_to_back"}, 64'(iss_cyc[n-1] - iss_cyc[0]), 64'(n - 1));
    @(negedge clk);
    chk({nm, ".done_single"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [11:0] b;
    int c;
    for (int i = 0; i < 4096; i++) mem[i] = 64'(i);
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.sp_rd_en", 64'(sp_rd_en), 64'd0);
    chk("rst.sp_addr", 64'(sp_addr), 64'd0);
    chk("rst.sp_stall", 64'(sp_stall), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    run_cmd("t1", 12'h010, 4, 0, 0, 1'b0);
    chk("t1.first_word", out_q.size() > 0 ? out_q[0] : 64'hx, 64'h10);
    run_cmd("t2", 12'hFFE, 4, 0, 0, 1'b0);
    chk("t2.wrap_addr", 64'(iss_q.size() > 2 ? iss_q[2] : 12'hx), 64'h000);

    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    run_cmd("t3", 12'(($urandom_range(0, 4095))), 40, 0, 2, 1'b0);
    run_cmd("t4", 12'h7F0, 8, 1, 0, 1'b0);
    run_cmd("t5a", 12'h055, 0, 0, 0, 1'b0);
    run_cmd("t5b", 12'h200, 6, 0, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      b = 12'($urandom_range(0, 4095));
      c = $urandom_range(1, 48);
      run_cmd("rnd", b, c, 2, 1, 1'b0);
    end

    // abort mid-command with reads still in flight
    iss_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 12'h400; count = 16'd20;
    c = 0;
    do begin @(negedge clk); start = 1'b0; c++; end while (iss_q.size() < 5 && c < 100);
    chk("t6.reached5", 64'(iss_q.size() >= 5), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6.busy", 64'(busy), 64'd0);
    chk("t6.out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6.late_dropped", {62'd0, out_valid, busy}, 64'd0);
    run_cmd("t6b", 12'h123, 2, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
